// File: rtl/mesh_pkg.sv
// Shared definitions for the mesh controller: FSM state encoding, skew
// payload layout and the DRAIN length helper.
package mesh_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PRELOAD = 3'd1,
    ST_COMPUTE = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_DONE    = 3'd4
  } mesh_state_e;

  // Per-column control payload carried down the skew lines.
  localparam int unsigned PAYLOAD_W = 3;
  localparam int unsigned PL_VALID  = 2;
  localparam int unsigned PL_PROP   = 1;
  localparam int unsigned PL_DF     = 0;

  // Cycles spent in DRAIN: enough for the last beat to cross the whole
  // diagonal wavefront of a rows x cols mesh.
  function automatic int unsigned drain_cycles(input int unsigned rows,
                                               input int unsigned cols);
    return rows + cols - 1;
  endfunction

endpackage

// File: rtl/mesh_skew_line.sv
// Fixed-depth delay line for one column's 3-bit control payload.
// Every stage shifts each cycle; reset clears all stages.
module mesh_skew_line #(
  parameter int unsigned DEPTH = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] din,
  output logic [2:0] dout
);

  logic [2:0] stage_q [DEPTH];
  logic [2:0] stage_d [DEPTH];

  // Next stage values: input enters stage 0, everything else moves down.
  always_comb begin
    stage_d[0] = din;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // Stage registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/mesh_controller.sv
// Mesh controller: sequences PRELOAD / COMPUTE / DRAIN for a systolic mesh
// and emits diagonally skewed per-column valid/propagate/dataflow controls.
// Optional feature: define MESH_CTRL_STALL_CNT_EN to add the stall_count
// output counting upstream-starved streaming cycles.
module mesh_controller
  import mesh_pkg::*;
#(
  parameter int unsigned MESHROWS    = 4,
  parameter int unsigned MESHCOLUMNS = 4,
  parameter int unsigned LENWIDTH    = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_dataflow,
  input  logic [LENWIDTH-1:0]    cmd_len,
  input  logic                   src_valid,
  output logic                   src_ready,
  output logic [MESHCOLUMNS-1:0] mesh_valid,
  output logic [MESHCOLUMNS-1:0] mesh_propagate,
  output logic [MESHCOLUMNS-1:0] mesh_dataflow,
  output logic                   busy,
  output logic                   done
`ifdef MESH_CTRL_STALL_CNT_EN
  ,
  output logic [31:0]            stall_count
`endif
);

  localparam int unsigned       DRAIN_LEN    = drain_cycles(MESHROWS, MESHCOLUMNS);
  localparam logic [LENWIDTH-1:0] ONE          = LENWIDTH'(1);
  localparam logic [LENWIDTH-1:0] PRELOAD_LAST = LENWIDTH'(MESHROWS - 1);
  localparam logic [LENWIDTH-1:0] DRAIN_LAST   = LENWIDTH'(DRAIN_LEN - 1);

  mesh_state_e           state_q, state_d;
  logic [LENWIDTH-1:0]   cnt_q, cnt_d;
  logic [LENWIDTH-1:0]   len_q, len_d;
  logic                  df_q, df_d;
  logic                  prop_q, prop_d;
  logic [PAYLOAD_W-1:0]  col0_q, col0_d;
  logic [PAYLOAD_W-1:0]  col_pl [MESHCOLUMNS];
  logic                  streaming;
  logic                  beat;

  assign streaming = (state_q == ST_PRELOAD) || (state_q == ST_COMPUTE);
  assign beat      = streaming && src_valid;

  // Handshake and status outputs decoded from the current state.
  always_comb begin
    cmd_ready = reset && (state_q == ST_IDLE);
    src_ready = streaming;
    busy      = (state_q != ST_IDLE);
    done      = (state_q == ST_DONE);
  end

  // Next-state and command bookkeeping. The one counter serves as beat
  // counter while streaming and as cycle counter in DRAIN; it is cleared
  // at every phase change so each phase starts counting from zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    df_d    = df_q;
    prop_d  = prop_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          len_d   = cmd_len;
          df_d    = cmd_dataflow;
          prop_d  = ~prop_q;
          cnt_d   = '0;
          state_d = ST_PRELOAD;
        end
      end
      ST_PRELOAD: begin
        if (src_valid) begin
          if (cnt_q == PRELOAD_LAST) begin
            cnt_d   = '0;
            state_d = (len_q == '0) ? ST_DRAIN : ST_COMPUTE;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
      end
      ST_COMPUTE: begin
        if (src_valid) begin
          if (cnt_q == len_q - ONE) begin
            cnt_d   = '0;
            state_d = ST_DRAIN;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
      end
      ST_DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Column 0 controls: a valid payload on a beat, an all-zero bubble otherwise.
  always_comb begin
    col0_d = '0;
    if (beat) begin
      col0_d[PL_VALID] = 1'b1;
      col0_d[PL_PROP]  = (state_q == ST_PRELOAD) ? prop_q : ~prop_q;
      col0_d[PL_DF]    = df_q;
    end
  end

  // FSM, command latches and column 0 register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      df_q    <= 1'b0;
      prop_q  <= 1'b0;
      col0_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      df_q    <= df_d;
      prop_q  <= prop_d;
      col0_q  <= col0_d;
    end
  end

  // Diagonal skew: column j is column j-1 delayed one more cycle, so column
  // j sees column 0's controls exactly j cycles later.
  assign col_pl[0] = col0_q;

  for (genvar j = 1; j < MESHCOLUMNS; j++) begin : g_skew
    mesh_skew_line #(
      .DEPTH(1)
    ) u_skew (
      .clock(clock),
      .reset(reset),
      .din  (col_pl[j-1]),
      .dout (col_pl[j])
    );
  end

  // Unpack per-column payloads onto the mesh edge buses.
  always_comb begin
    mesh_valid     = '0;
    mesh_propagate = '0;
    mesh_dataflow  = '0;
    for (int unsigned j = 0; j < MESHCOLUMNS; j++) begin
      mesh_valid[j]     = col_pl[j][PL_VALID];
      mesh_propagate[j] = col_pl[j][PL_PROP];
      mesh_dataflow[j]  = col_pl[j][PL_DF];
    end
  end

`ifdef MESH_CTRL_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  // Starved streaming cycles since the last accepted command, saturating.
  always_comb begin
    stall_d = stall_q;
    if ((state_q == ST_IDLE) && cmd_valid) begin
      stall_d = '0;
    end else if (streaming && !src_valid && (stall_q != '1)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_mesh_controller.sv
// Testbench for mesh_controller (4x4, LENWIDTH=8): a hand-written table for
// the basic command, directed corner sequences, then random traffic, all
// compared every cycle against a beat-counting reference model.
module tb_mesh_controller;

  localparam int MR = 4;
  localparam int MC = 4;
  localparam int LW = 8;
  localparam int DR = MR + MC - 1;
  localparam int OW = 4 + 3 * MC;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_dataflow = 1'b0;
  logic [LW-1:0] cmd_len = '0;
  logic          src_valid = 1'b0;
  logic          src_ready;
  logic [MC-1:0] mesh_valid;
  logic [MC-1:0] mesh_propagate;
  logic [MC-1:0] mesh_dataflow;
  logic          busy;
  logic          done;
`ifdef MESH_CTRL_STALL_CNT_EN
  logic [31:0]   stall_count;
`endif

  always #5 clock = ~clock;

  mesh_controller #(
    .MESHROWS   (MR),
    .MESHCOLUMNS(MC),
    .LENWIDTH   (LW)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_dataflow  (cmd_dataflow),
    .cmd_len       (cmd_len),
    .src_valid     (src_valid),
    .src_ready     (src_ready),
    .mesh_valid    (mesh_valid),
    .mesh_propagate(mesh_propagate),
    .mesh_dataflow (mesh_dataflow),
    .busy          (busy),
    .done          (done)
`ifdef MESH_CTRL_STALL_CNT_EN
    ,
    .stall_count   (stall_count)
`endif
  );

  logic [OW-1:0] dut_vec;
  assign dut_vec = {cmd_ready, src_ready, busy, done, mesh_valid, mesh_propagate, mesh_dataflow};

  int vectors = 0;
  int miscompares = 0;
  int beat_cnt = 0;
  int acc_cnt = 0;
  int done_cnt = 0;

  // Reference model: a command is R+len beats, then DR idle cycles, then a
  // one-cycle done; column j shows the column-0 payload from j cycles ago.
  bit          m_active, m_done, m_df, m_prop;
  int          m_len, m_beats, m_drain;
  logic [2:0]  m_hist [MC];
  logic [31:0] m_stall;

  task automatic model_reset();
    m_active = 0; m_done = 0; m_df = 0; m_prop = 0;
    m_len = 0; m_beats = 0; m_drain = 0; m_stall = '0;
    for (int j = 0; j < MC; j++) m_hist[j] = '0;
  endtask

  function automatic logic [OW-1:0] model_out();
    logic [MC-1:0] v, p, d;
    for (int j = 0; j < MC; j++) begin
      v[j] = m_hist[j][2]; p[j] = m_hist[j][1]; d[j] = m_hist[j][0];
    end
    return {!m_active && !m_done, m_active && (m_beats < MR + m_len),
            m_active || m_done, m_done, v, p, d};
  endfunction

  task automatic model_edge();
    int total = MR + m_len;
    bit in_stream = m_active && (m_beats < total);
    bit beat = in_stream && src_valid;
    logic [2:0] pl = '0;
    if (beat) pl = {1'b1, (m_beats < MR) ? m_prop : ~m_prop, m_df};
    for (int j = MC - 1; j > 0; j--) m_hist[j] = m_hist[j-1];
    m_hist[0] = pl;
    if (in_stream && !src_valid && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
    if (m_done) begin
      m_done = 0;
    end else if (!m_active) begin
      if (cmd_valid) begin
        m_active = 1; m_len = int'(cmd_len); m_df = cmd_dataflow;
        m_prop = ~m_prop; m_beats = 0; m_drain = 0; m_stall = '0;
      end
    end else if (beat) begin
      m_beats++;
    end else if (!in_stream) begin
      m_drain++;
      if (m_drain == DR) begin m_active = 0; m_done = 1; end
    end
  endtask

  task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic check_int(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // One clock: model advances on the same inputs, outputs compared at +1.
  task automatic step();
    if (src_valid && src_ready) beat_cnt++;
    if (cmd_valid && cmd_ready) acc_cnt++;
    model_edge();
    @(posedge clock);
    #1;
    if (done) done_cnt++;
    check("cycle", dut_vec, model_out());
`ifdef MESH_CTRL_STALL_CNT_EN
    check_int("stall_count", stall_count, m_stall);
`endif
  endtask

  task automatic run_until_done(input int budget, input string name);
    int n = 0;
    while (!done && n < budget) begin step(); n++; end
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL %s: no done within %0d cycles", name, budget);
    end
  endtask

  typedef struct {
    bit            cv;
    bit            sv;
    logic [LW-1:0] clen;
    logic [OW-1:0] exp;
  } vec_t;

  function automatic vec_t mk(bit cv, logic [3:0] ctl, logic [3:0] mv, logic [3:0] mp);
    vec_t r;
    r.cv = cv; r.sv = 1'b1; r.clen = 8'd3;
    r.exp = {ctl, mv, mp, mv};
    return r;
  endfunction

  vec_t tbl [16];
  bit   props [$];

  initial begin
    int n, comp, acc0, prop_exp;
    bit armed;

    model_reset();
    #2;
    check("reset_state", dut_vec, '0);
    reset = 1'b1;
    #1;
    check("after_release", dut_vec, model_out());

    // Basic command: len=3, dataflow=1, src always valid. ctl={cr,sr,busy,done}.
    tbl[0]  = mk(1, 4'b0110, 4'b0000, 4'b0000);
    tbl[1]  = mk(0, 4'b0110, 4'b0001, 4'b0001);
    tbl[2]  = mk(0, 4'b0110, 4'b0011, 4'b0011);
    tbl[3]  = mk(0, 4'b0110, 4'b0111, 4'b0111);
    tbl[4]  = mk(0, 4'b0110, 4'b1111, 4'b1111);
    tbl[5]  = mk(0, 4'b0110, 4'b1111, 4'b1110);
    tbl[6]  = mk(0, 4'b0110, 4'b1111, 4'b1100);
    tbl[7]  = mk(0, 4'b0010, 4'b1111, 4'b1000);
    tbl[8]  = mk(0, 4'b0010, 4'b1110, 4'b0000);
    tbl[9]  = mk(0, 4'b0010, 4'b1100, 4'b0000);
    tbl[10] = mk(0, 4'b0010, 4'b1000, 4'b0000);
    tbl[11] = mk(0, 4'b0010, 4'b0000, 4'b0000);
    tbl[12] = mk(0, 4'b0010, 4'b0000, 4'b0000);
    tbl[13] = mk(0, 4'b0010, 4'b0000, 4'b0000);
    tbl[14] = mk(0, 4'b0011, 4'b0000, 4'b0000);
    tbl[15] = mk(0, 4'b1000, 4'b0000, 4'b0000);
    cmd_dataflow = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cmd_valid = tbl[i].cv; src_valid = tbl[i].sv; cmd_len = tbl[i].clen;
      step();
      check($sformatf("table[%0d]", i), dut_vec, tbl[i].exp);
    end

    // len=0: PRELOAD straight to DRAIN, no complement propagate visible.
    cmd_valid = 1; cmd_len = 0; cmd_dataflow = 0; src_valid = 1;
    step();
    cmd_valid = 0;
    prop_exp = m_prop;
    comp = 0; n = 0;
    while (!done && n < 50) begin
      step(); n++;
      for (int j = 0; j < MC; j++)
        if (mesh_valid[j] && (int'(mesh_propagate[j]) != prop_exp)) comp++;
    end
    check_int("len0_complement_seen", comp, 0);
    check_int("len0_accept_to_done", n, MR + DR);
    step();

    // Two-cycle starvation mid-COMPUTE.
    cmd_valid = 1; cmd_len = 6; cmd_dataflow = 1; src_valid = 1;
    step();
    cmd_valid = 0;
    for (int i = 0; i < MR + 2; i++) step();
    src_valid = 0; step(); step();
    src_valid = 1;
    run_until_done(40, "stall_cmd");
    step();
`ifdef MESH_CTRL_STALL_CNT_EN
    check_int("stall_total", stall_count, 2);
`endif

    // Maximum length streams every beat without wrapping.
    beat_cnt = 0;
    cmd_valid = 1; cmd_len = 8'hFF; cmd_dataflow = 0; src_valid = 1;
    step();
    cmd_valid = 0;
    run_until_done(400, "maxlen_cmd");
    check_int("maxlen_beats", beat_cnt, MR + 255);
    step();

    // Reset pulsed during COMPUTE.
    done_cnt = 0;
    cmd_valid = 1; cmd_len = 5; cmd_dataflow = 1; src_valid = 1;
    step();
    cmd_valid = 0;
    for (int i = 0; i < MR + 1; i++) step();
    #2 reset = 1'b0;
    #1 check("reset_mid_compute", dut_vec, '0);
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    #1 check("reset_mid_release", dut_vec, model_out());
    for (int i = 0; i < 20; i++) step();
    check_int("no_done_after_reset", done_cnt, 0);

    // Back-to-back with cmd_valid held: propagate 1 then 0, two accepts.
    done_cnt = 0; acc0 = acc_cnt; armed = 0;
    cmd_valid = 1; cmd_len = 2; cmd_dataflow = 0; src_valid = 1;
    n = 0;
    while (done_cnt < 2 && n < 100) begin
      if (cmd_valid && cmd_ready) armed = 1;
      step(); n++;
      if (armed && mesh_valid[0]) begin props.push_back(mesh_propagate[0]); armed = 0; end
    end
    cmd_valid = 0;
    step();
    check_int("b2b_dones", done_cnt, 2);
    check_int("b2b_accepts", acc_cnt - acc0, 2);
    check_int("b2b_prop_count", props.size(), 2);
    if (props.size() == 2) begin
      check_int("b2b_prop_first", props[0], 1);
      check_int("b2b_prop_second", props[1], 0);
    end

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      cmd_valid    = ($urandom_range(0, 3) != 0);
      cmd_len      = LW'($urandom_range(0, 9));
      cmd_dataflow = $urandom_range(0, 1);
      src_valid    = ($urandom_range(0, 3) != 0);
      step();
    end
    cmd_valid = 0; src_valid = 1;
    n = 0;
    while (busy && n < 100) begin step(); n++; end
    check_int("random_returns_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
